dice_game_ctrl: RTL and testbench

- Two-player turn scheduler that shares a single electronic dice between two button requesters.
- Forwards only the active player's button to the dice as `roll`.
- After release, waits a settle time, captures `throw`, accumulates per-player scores and alternates turns.
- Declares a winner at TARGET. Sits between the board push-buttons and the dice block.

---
 rtl/dice_game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dice_game_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dice_game_ctrl
//  Purpose  : Two-player turn scheduler sharing one electronic dice. Forwards
//             the active player's button to the dice as roll, waits a settle
//             time after release, samples throw, accumulates per-player
//             scores, alternates turns and declares a winner at TARGET.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             btn_p1, btn_p2  - synchronised player buttons (level)
//             new_game        - single-cycle restart request
//             throw[2:0]      - dice value (valid 1..6)
//             roll            - dice button drive (high while rolling)
//             turn            - active player (0 = P1, 1 = P2)
//             score1, score2  - player totals (saturating)
//             last_throw      - value captured on the latest scoring cycle
//             game_over       - high once a player reached TARGET
//             winner          - winning player, valid while game_over
//             bad_throw       - sticky: a captured throw was 0 or 7
//  Options  : SIX_REROLL_EN   - a non-winning valid 6 keeps the same player
//  Revision : 1.0 - initial release
// ============================================================================
module dice_game_ctrl #(
   parameter int TARGET  = 20,
   parameter int SCORE_W = 6,
   parameter int SETTLE  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_p1,
   input  logic               btn_p2,
   input  logic               new_game,
   input  logic [2:0]         throw,
   output logic               roll,
   output logic               turn,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [2:0]         last_throw,
   output logic               game_over,
   output logic               winner,
   output logic               bad_throw
);

   typedef enum logic [2:0] {
      S_WAIT_PRESS = 3'd0,
      S_ROLLING    = 3'd1,
      S_SETTLE     = 3'd2,
      S_SCORE      = 3'd3,
      S_GAME_OVER  = 3'd4
   } state_t;

   localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE - 1);
   localparam logic [SCORE_W-1:0] TARGET_V    = SCORE_W'(TARGET);

   state_t             state_q, state_d;
   logic               turn_q, turn_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic [2:0]         last_throw_q, last_throw_d;
   logic               winner_q, winner_d;
   logic               bad_throw_q, bad_throw_d;
   logic [3:0]         cnt_q, cnt_d;

   logic               act_btn;
   logic               throw_ok;
   logic [2:0]         pts;
   logic [SCORE_W-1:0] cur_score;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W-1:0] new_score;

   always_comb begin
      state_d      = state_q;
      turn_d       = turn_q;
      score1_d     = score1_q;
      score2_d     = score2_q;
      last_throw_d = last_throw_q;
      winner_d     = winner_q;
      bad_throw_d  = bad_throw_q;
      cnt_d        = cnt_q;

      act_btn   = turn_q ? btn_p2 : btn_p1;
      throw_ok  = (throw != 3'd0) && (throw != 3'd7);
      pts       = throw_ok ? throw : 3'd0;
      cur_score = turn_q ? score2_q : score1_q;
      // One extra bit catches the carry so the total can clamp at all-ones.
      sum       = {1'b0, cur_score} + (SCORE_W+1)'(pts);
      new_score = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

      case (state_q)
         S_WAIT_PRESS: begin
            if (act_btn) state_d = S_ROLLING;
         end
         S_ROLLING: begin
            if (!act_btn) begin
               state_d = S_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end
         end
         S_SETTLE: begin
            // Buttons are deliberately not looked at here.
            if (cnt_q == 4'd0) state_d = S_SCORE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_SCORE: begin
            last_throw_d = throw;
            if (!throw_ok) bad_throw_d = 1'b1;
            if (turn_q) score2_d = new_score;
            else        score1_d = new_score;
            if (new_score >= TARGET_V) begin
               winner_d = turn_q;
               state_d  = S_GAME_OVER;
            end else begin
               state_d = S_WAIT_PRESS;
`ifdef SIX_REROLL_EN
               if (throw != 3'd6) turn_d = ~turn_q;
`else
               turn_d = ~turn_q;
`endif
            end
         end
         S_GAME_OVER: begin
            state_d = S_GAME_OVER;
         end
         default: begin
            state_d = S_WAIT_PRESS;
         end
      endcase

      // A restart wins over whatever the FSM decided this cycle.
      if (new_game) begin
         state_d      = S_WAIT_PRESS;
         turn_d       = 1'b0;
         score1_d     = '0;
         score2_d     = '0;
         last_throw_d = 3'd0;
         winner_d     = 1'b0;
         bad_throw_d  = 1'b0;
         cnt_d        = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_WAIT_PRESS;
         turn_q       <= 1'b0;
         score1_q     <= '0;
         score2_q     <= '0;
         last_throw_q <= 3'd0;
         winner_q     <= 1'b0;
         bad_throw_q  <= 1'b0;
         cnt_q        <= 4'd0;
      end else begin
         state_q      <= state_d;
         turn_q       <= turn_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         last_throw_q <= last_throw_d;
         winner_q     <= winner_d;
         bad_throw_q  <= bad_throw_d;
         cnt_q        <= cnt_d;
      end
   end

   // Decoded from the registered state only, so no button reaches roll
   // combinationally.
   assign roll       = (state_q == S_ROLLING);
   assign game_over  = (state_q == S_GAME_OVER);
   assign turn       = turn_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign last_throw = last_throw_q;
   assign winner     = winner_q;
   assign bad_throw  = bad_throw_q;

endmodule
`default_nettype wire

// File: tb/tb_dice_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dice_game_ctrl
//  Purpose  : Self-checking bench for dice_game_ctrl. A turn-level model
//             predicts every output; a compare process checks them each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dice_game_ctrl;

   localparam int TARGET  = 20;
   localparam int SCORE_W = 6;
   localparam int SETTLE  = 2;
   localparam int MAXS    = (1 << SCORE_W) - 1;
`ifdef SIX_REROLL_EN
   localparam bit REROLL = 1'b1;
`else
   localparam bit REROLL = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               btn_p1 = 1'b0;
   logic               btn_p2 = 1'b0;
   logic               new_game = 1'b0;
   logic [2:0]         throw = 3'd1;
   logic               roll, turn, game_over, winner, bad_throw;
   logic [SCORE_W-1:0] score1, score2;
   logic [2:0]         last_throw;

   dice_game_ctrl #(.TARGET(TARGET), .SCORE_W(SCORE_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .btn_p1(btn_p1), .btn_p2(btn_p2),
      .new_game(new_game), .throw(throw), .roll(roll), .turn(turn),
      .score1(score1), .score2(score2), .last_throw(last_throw),
      .game_over(game_over), .winner(winner), .bad_throw(bad_throw)
   );

   always #5 clk = ~clk;

   // Expected outputs after the most recent rising edge.
   int         e_s1, e_s2;
   logic       e_turn, e_roll, e_go, e_win, e_bad;
   logic [2:0] e_last;
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("roll", int'(roll), int'(e_roll));
         chk("turn", int'(turn), int'(e_turn));
         chk("score1", int'(score1), e_s1);
         chk("score2", int'(score2), e_s2);
         chk("last_throw", int'(last_throw), int'(e_last));
         chk("game_over", int'(game_over), int'(e_go));
         chk("bad_throw", int'(bad_throw), int'(e_bad));
         if (e_go) chk("winner", int'(winner), int'(e_win));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      e_s1 = 0; e_s2 = 0; e_turn = 1'b0; e_roll = 1'b0;
      e_go = 1'b0; e_win = 1'b0; e_bad = 1'b0; e_last = 3'd0;
   endtask

   // Active player's button set to act, the other one random.
   task automatic drive_btns(input bit act);
      if (e_turn) begin
         btn_p2 = act; btn_p1 = 1'($urandom_range(0, 1));
      end else begin
         btn_p1 = act; btn_p2 = 1'($urandom_range(0, 1));
      end
   endtask

   // Apply the scoring rules for one captured throw.
   task automatic model_score(input logic [2:0] t);
      int pts, ns;
      pts    = (t >= 1 && t <= 6) ? int'(t) : 0;
      e_last = t;
      if (pts == 0) e_bad = 1'b1;
      ns = (e_turn ? e_s2 : e_s1) + pts;
      if (ns > MAXS) ns = MAXS;
      if (e_turn) e_s2 = ns; else e_s1 = ns;
      if (ns >= TARGET) begin
         e_go = 1'b1; e_win = e_turn;
      end else if (!(REROLL && t == 3'd6)) begin
         e_turn = ~e_turn;
      end
   endtask

   // One full turn: hold for 'hold' cycles, release, settle, score t.
   task automatic do_turn(input int hold, input logic [2:0] t);
      drive_btns(1'b1); step(); e_roll = 1'b1;
      repeat (hold - 1) begin drive_btns(1'b1); step(); end
      drive_btns(1'b0); step(); e_roll = 1'b0;
      // Settle window: buttons and throw are junk and must be ignored.
      repeat (SETTLE) begin
         btn_p1 = 1'($urandom_range(0, 1));
         btn_p2 = 1'($urandom_range(0, 1));
         throw  = 3'($urandom_range(0, 7));
         step();
      end
      throw = t; btn_p1 = 1'b0; btn_p2 = 1'b0;
      step();
      model_score(t);
      drive_btns(1'b0);
      throw = 3'($urandom_range(0, 7));
   endtask

   task automatic idle(input int n);
      repeat (n) begin drive_btns(1'b0); step(); end
   endtask

   task automatic poke_game_over(input int n);
      repeat (n) begin
         btn_p1 = 1'($urandom_range(0, 1));
         btn_p2 = 1'($urandom_range(0, 1));
         step();
      end
   endtask

   task automatic do_new_game();
      new_game = 1'b1; btn_p1 = 1'b0; btn_p2 = 1'b0;
      step();
      new_game = 1'b0;
      model_reset();
   endtask

   task automatic lit(input string name, input int act, input int exp);
      chk(name, act, exp);
   endtask

   initial begin
      logic [2:0] seq1 [7];
      logic [2:0] t;
      if (MAXS < TARGET + 5) begin
         $display("FAIL param_check: score max %0d below required %0d", MAXS, TARGET + 5);
         $fatal(1);
      end
      model_reset();
      step(); step();
      chk_en = 1'b1;
      rst = 1'b0;
      lit("reset_score1", int'(score1), 0);
      lit("reset_turn", int'(turn), 0);

      // Inactive player's button must be ignored.
      btn_p1 = 1'b0; btn_p2 = 1'b1;
      repeat (4) step();
      btn_p2 = 1'b0;
      lit("idle_p2_roll", int'(roll), 0);
      lit("idle_p2_turn", int'(turn), 0);
      step();

      // P1 holds 10 cycles and throws 4.
      do_turn(10, 3'd4);
      lit("t4_model_s1", e_s1, 4);
      lit("t4_score1", int'(score1), 4);
      lit("t4_last", int'(last_throw), 4);
      lit("t4_turn", int'(turn), 1);
      idle(2);

      // Race to 20, including a bad (0) throw.
      do_new_game();
      seq1 = '{3'd5, 3'd6, 3'd5, 3'd6, 3'd5, 3'd0, 3'd5};
      foreach (seq1[i]) begin
         do_turn(int'($urandom_range(1, 4)), seq1[i]);
         idle(1);
      end
      lit("race_game_over", int'(game_over), 1);
      lit("race_bad", int'(bad_throw), 1);
      if (!REROLL) begin
         lit("race_model_s1", e_s1, 20);
         lit("race_score1", int'(score1), 20);
         lit("race_score2", int'(score2), 12);
         lit("race_winner", int'(winner), 0);
      end
      poke_game_over(6);
      lit("held_score1", int'(score1), e_s1);
      do_new_game();
      lit("ng_bad_cleared", int'(bad_throw), 0);

      // Build score2 = 9, then abort a roll with new_game.
      do_turn(2, 3'd1); do_turn(2, 3'd5); do_turn(2, 3'd1); do_turn(2, 3'd4);
      lit("pre_abort_score2", int'(score2), 9);
      drive_btns(1'b1); step(); e_roll = 1'b1;
      drive_btns(1'b1); step();
      new_game = 1'b1;
      step();
      new_game = 1'b0; model_reset();
      btn_p1 = 1'b0; btn_p2 = 1'b0;
      lit("abort_roll", int'(roll), 0);
      lit("abort_score2", int'(score2), 0);
      step();

      // rst and new_game together.
      do_turn(3, 3'd3);
      rst = 1'b1; new_game = 1'b1;
      step();
      rst = 1'b0; new_game = 1'b0; model_reset();
      lit("rst_ng_score1", int'(score1), 0);

      // Six handling.
      do_turn(3, 3'd6);
      lit("six_score1", int'(score1), 6);
      lit("six_turn", int'(turn), REROLL ? 0 : 1);
      do_turn(2, 3'd3);
      if (REROLL) begin
         lit("six_next_score1", int'(score1), 9);
         lit("six_next_turn", int'(turn), 1);
      end else begin
         lit("six_next_score2", int'(score2), 3);
         lit("six_next_turn", int'(turn), 0);
      end
      idle(1);

      // Randomized play.
      for (int k = 0; k < 300; k++) begin
         if (e_go) begin
            poke_game_over(int'($urandom_range(1, 3)));
            do_new_game();
         end else if ($urandom_range(0, 29) == 0) begin
            do_new_game();
         end else begin
            if ($urandom_range(0, 9) == 0)
               t = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0;
            else
               t = 3'($urandom_range(1, 6));
            do_turn(int'($urandom_range(1, 6)), t);
            idle(int'($urandom_range(0, 2)));
         end
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
